// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
// No logic: state encoding, default geometry and the error-address mask helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_AW      = 5;
    localparam int DEF_LATENCY = 2;

    // Bits that must be zero for a legal word access: the two byte-offset bits
    // plus everything above the word index.
    function automatic logic [31:0] err_mask(input int aw);
        return ~((32'd1 << (aw + 2)) - 32'd1) | 32'd3;
    endfunction

    localparam logic [31:0] DEF_ERR_MASK = err_mask(DEF_AW);

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data store, 2**AW x 32, no reset.
// Latency: write takes effect at the clock edge, read is combinational.
// Backpressure: none; the caller qualifies the write enable.
module dmem_array #(
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder for the MEM stage; one request outstanding at a time.
// Latency: response strobe LATENCY+1 cycles after acceptance, one cycle wide.
// Backpressure: req_ready only in IDLE; stall_out freezes the pipeline until the response cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_out
);

    localparam logic [31:0] ERR_MASK = err_mask(AW);
    localparam logic [3:0]  LAST_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        accept;
    logic        addr_err;
    logic        mem_we;
    logic [31:0] mem_rdata;

    assign accept   = (state == IDLE) && req_valid;
    assign addr_err = |(cap_addr & ERR_MASK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cnt       <= 4'd0;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The write lands on the edge leaving RESP; a reset before that edge leaves state!=RESP.
    assign mem_we = (state == RESP) && cap_we && !addr_err;

    dmem_array #(
        .AW(AW)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .addr  (cap_addr[AW+1:2]),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

    assign req_ready  = (state == IDLE);
    assign stall_out  = accept || (state == WAIT);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && addr_err;
    assign resp_rdata = ((state == RESP) && !cap_we && !addr_err) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_dmem_responder;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;

    logic        a_valid, a_ready, a_we, a_resp_valid, a_resp_err, a_stall;
    logic [31:0] a_addr, a_wdata, a_resp_rdata;
    logic        b_valid, b_ready, b_we, b_resp_valid, b_resp_err, b_stall;
    logic [31:0] b_addr, b_wdata, b_resp_rdata;

    int          checks = 0;
    int          errors = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] ma [32];
    logic [31:0] mb [32];

    always #5 clock = ~clock;

    dmem_responder #(.AW(5), .LATENCY(2)) u_dut_a (
        .clock(clock), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_addr(a_addr), .req_wdata(a_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .stall_out(a_stall)
    );

    dmem_responder #(.AW(5), .LATENCY(0)) u_dut_b (
        .clock(clock), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .stall_out(b_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'd0) || (addr[31:7] != 25'd0);
    endfunction

    task automatic push_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.err   = addr_bad(addr);
        e.rdata = (e.err || we) ? 32'd0 : ma[addr[6:2]];
        if (we && !e.err) ma[addr[6:2]] = wdata;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.err   = addr_bad(addr);
        e.rdata = (e.err || we) ? 32'd0 : mb[addr[6:2]];
        if (we && !e.err) mb[addr[6:2]] = wdata;
        qb.push_back(e);
    endtask

    // Full transaction on the LATENCY=2 instance, entered and left on a falling edge.
    task automatic xact_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int cyc;
        int stalls;
        stalls  = 0;
        a_valid = 1'b1;
        a_we    = we;
        a_addr  = addr;
        a_wdata = wdata;
        #1;
        check("a_ready_idle", a_ready, 1'b1);
        if (a_stall) stalls++;
        push_a(we, addr, wdata);
        @(negedge clock);
        a_valid = 1'b0;
        a_addr  = 32'hFFFF_FFFF;
        a_wdata = 32'h0BAD_0BAD;
        cyc = 1;
        while (!a_resp_valid && cyc < 20) begin
            if (a_stall) stalls++;
            @(negedge clock);
            cyc++;
        end
        check("a_latency", cyc, 3);
        check("a_stall_cycles", stalls, 3);
        check("a_stall_in_resp", a_stall, 1'b0);
        check("a_ready_in_resp", a_ready, 1'b0);
        @(negedge clock);
        check("a_resp_one_cycle", a_resp_valid, 1'b0);
    endtask

    always @(negedge clock) begin : mon_a
        exp_t e;
        if (a_resp_valid) begin
            if (qa.size() == 0) begin
                check("a_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_rdata", a_resp_rdata, e.rdata);
                check("a_err", a_resp_err, e.err);
            end
        end
    end

    always @(negedge clock) begin : mon_b
        exp_t e;
        if (b_resp_valid) begin
            if (qb.size() == 0) begin
                check("b_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_rdata", b_resp_rdata, e.rdata);
                check("b_err", b_resp_err, e.err);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic        bwe [6];
        logic [31:0] badd[6];
        logic [31:0] bdat[6];
        int          cyc;

        reset   = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;

        repeat (3) @(negedge clock);
        check("rst_ready", a_ready, 1'b1);
        check("rst_resp_valid", a_resp_valid, 1'b0);
        check("rst_stall", a_stall, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", a_ready, 1'b1);
        check("post_rst_resp_valid", a_resp_valid, 1'b0);
        check("post_rst_rdata", a_resp_rdata, 32'd0);
        check("post_rst_err", a_resp_err, 1'b0);
        check("post_rst_stall", a_stall, 1'b0);
        check("post_rst_b_ready", b_ready, 1'b1);

        xact_a(1'b1, 32'h0000_0000, 32'h1111_1111);
        xact_a(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        xact_a(1'b0, 32'h0000_0008, 32'h0);
        xact_a(1'b0, 32'h0000_0006, 32'h0);
        xact_a(1'b1, 32'h0000_0080, 32'hCAFE_F00D);
        xact_a(1'b0, 32'h0000_0000, 32'h0);
        xact_a(1'b1, 32'h0000_0004, 32'h5555_AAAA);

        // Asynchronous reset while waiting: back to IDLE without a clock edge.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 32'h8;
        push_a(1'b0, 32'h8, 32'h0);
        @(negedge clock);
        a_valid = 1'b0;
        check("a_stall_in_wait", a_stall, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_wait_ready", a_ready, 1'b1);
        check("rst_wait_stall", a_stall, 1'b0);
        check("rst_wait_resp_valid", a_resp_valid, 1'b0);
        void'(qa.pop_back());
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Reset during the response of a store: the write must not land.
        a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h4; a_wdata = 32'h0000_1234;
        qa.push_back({1'b0, 32'd0});
        @(negedge clock);
        a_valid = 1'b0;
        cyc = 0;
        while (!a_resp_valid && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        check("a_resp_before_reset", a_resp_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_resp_valid_drop", a_resp_valid, 1'b0);
        check("rst_resp_ready", a_ready, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        xact_a(1'b0, 32'h0000_0004, 32'h0);

        // LATENCY=0: request held continuously, accepted every other cycle.
        bwe[0] = 1'b1; badd[0] = 32'h10;  bdat[0] = 32'h0000_00A0;
        bwe[1] = 1'b1; badd[1] = 32'h14;  bdat[1] = 32'h0000_00B1;
        bwe[2] = 1'b0; badd[2] = 32'h10;  bdat[2] = 32'h0;
        bwe[3] = 1'b0; badd[3] = 32'h14;  bdat[3] = 32'h0;
        bwe[4] = 1'b0; badd[4] = 32'h12;  bdat[4] = 32'h0;
        bwe[5] = 1'b1; badd[5] = 32'h100; bdat[5] = 32'h0000_0666;
        for (int i = 0; i < 6; i++) begin
            b_valid = 1'b1;
            b_we    = bwe[i];
            b_addr  = badd[i];
            b_wdata = bdat[i];
            #1;
            check("b_ready_accept", b_ready, 1'b1);
            check("b_stall_accept", b_stall, 1'b1);
            check("b_resp_idle", b_resp_valid, 1'b0);
            push_b(bwe[i], badd[i], bdat[i]);
            @(negedge clock);
            check("b_ready_resp", b_ready, 1'b0);
            check("b_stall_resp", b_stall, 1'b0);
            check("b_resp_valid", b_resp_valid, 1'b1);
            b_we    = 1'b1;
            b_addr  = 32'hFFFF_FFF0;
            b_wdata = 32'hBAD0_BAD0;
            @(negedge clock);
        end
        b_valid = 1'b0;
        b_we    = 1'b0;
        b_addr  = 32'h14;
        @(negedge clock);
        b_valid = 1'b1;
        push_b(1'b0, 32'h14, 32'h0);
        @(negedge clock);
        b_valid = 1'b0;
        @(negedge clock);

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the MEM stage of the pipelined MIPS core. It accepts one load/store request at a time over a valid/ready handshake. It inserts a programmable number of wait states, then returns a one-cycle response with read data and an error flag. While a request is outstanding it drives `stall_out`, which the pipeline controller uses to freeze the pipeline registers.

## Interface
Parameters:
- `AW`, 5: word-address width; storage depth is 2**AW 32-bit words.
- `LATENCY`, 2: wait-state cycles between acceptance and response; legal range 0..15.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  MEM stage presents a request.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address, taken from the ALU result.
- `req_wdata`  in  32  store data (the forwarded gprB value).
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or out-of-range access; valid with `resp_valid`.
- `stall_out`  out  1  pipeline must hold the MEM stage this cycle.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: capture we/addr/wdata and clear the wait counter.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
- **WAIT**
  - Counter increments each cycle.
  - When counter == LATENCY-1, next state is RESP.
- **RESP**
  - `resp_valid`=1 for exactly one cycle; next state is IDLE.
  - Load: `resp_rdata` = mem[word index].
  - Store: the array is written at the edge leaving RESP; `resp_rdata`=0.
- Word index = `req_addr[AW+1:2]`.
- Error condition: `req_addr[1:0]`≠0, or any bit of `req_addr[31:AW+2]` set.
  - Sets `resp_err`=1 and `resp_rdata`=0.
  - A store with an error is suppressed: no array write.
- `req_ready` = (state==IDLE). Requests are never accepted in WAIT or RESP.
- `stall_out` = (state==IDLE && `req_valid`) || state==WAIT.
  - It is low in RESP, so the pipeline advances at the RESP edge and latches `resp_rdata` into MEM/WB.
- Memory array contents are not reset. A read of a never-written word returns X in simulation, which is acceptable.

## Timing
- Acceptance edge is T. `resp_valid` is high in the cycle after edge T+LATENCY.
- Request-to-response latency is LATENCY+1 cycles. Minimum request spacing is LATENCY+2 cycles.
- LATENCY=0: IDLE→RESP directly; response arrives 1 cycle after acceptance.
- `stall_out` is combinational from `req_valid` in IDLE. All other outputs are registered or decoded from state only.
- Read-after-write: a load accepted in the cycle after a store's RESP sees the new data.
- Reset values: state=IDLE; counter=0; captured request=0; `req_ready`=1; `resp_valid`=0; `resp_rdata`=0; `resp_err`=0; `stall_out`=0 (with `req_valid` low).
- Reset asserted mid-operation (WAIT or RESP): immediately return to IDLE and drop the pending request. A store pending in RESP is not written, because the write enable is qualified by state==RESP at the clock edge.
- `req_addr`/`req_wdata` changes after acceptance are ignored.

## Structure
- Shared package `dmem_pkg`:
  - State encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Error-address mask helper constant.
  - Default LATENCY and AW values.
- Sub-module `dmem_array`: 2**AW×32, synchronous write, combinational read, no reset.
- FSM, counter, request capture and error decode live in `dmem_responder`.

## Test plan
- Reset sequence:
  - Hold `reset`=0 for 3 cycles, then release → `req_ready`=1, `resp_valid`=0, `stall_out`=0.
  - Assert `reset`=0 asynchronously mid-cycle during WAIT → state returns to IDLE immediately with no clock edge.
- Store 0xDEADBEEF to 0x0000_0008 with LATENCY=2:
  - `stall_out` high for 3 cycles.
  - `resp_valid` high in cycle 3 after acceptance.
  - `resp_err`=0.
  - A following load of 0x8 returns 0xDEADBEEF.
- Misaligned/out-of-range accesses:
  - Load 0x0000_0006 → `resp_err`=1, `resp_rdata`=0.
  - Store to 0x0000_0080 (AW=5) → `resp_err`=1, and a later load of 0x0 is unchanged.
- LATENCY=0:
  - Back-to-back requests are accepted every 2 cycles.
  - `resp_valid` arrives 1 cycle after each acceptance.
  - `stall_out` is high only in the acceptance cycle.
- Reset in RESP of a store of 0x1234 to 0x4:
  - No write occurs; a subsequent load of 0x4 returns the prior value.
  - `resp_valid` drops immediately.
